solver_scheduler: RTL and testbench

SOLVER_SCHEDULER -- requirements
Module: solver_scheduler

---
 rtl/solver_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_solver_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_scheduler.sv
// Dispatches jobs (header + limb stream) to one of two solver instances,
// tracks each solver as FREE / RUNNING / DONE and returns their results
// through a single round-robin result port.
module solver_scheduler #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int ID_BITS         = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [ID_BITS-1:0]         job_id,
  input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
  input  logic [15:0]                job_iter_lim,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_re,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_im,
  output logic [1:0]                 s_wr_real_en,
  output logic [1:0]                 s_wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] s_wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  s_real_data,
  output logic [LIMB_SIZE_BITS-1:0]  s_imag_data,
  output logic [1:0]                 s_wr_num_limbs_en,
  output logic [1:0]                 s_wr_iter_lim_en,
  output logic [LIMB_INDEX_BITS-1:0] s_num_limbs_data,
  output logic [15:0]                s_iter_lim_data,
  output logic [1:0]                 s_start,
  input  logic [1:0]                 s_out_ready,
  input  logic [31:0]                s_iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_BITS-1:0]         res_id,
  output logic [15:0]                res_iterations
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CFG, ST_START} state_t;
  typedef enum logic [1:0] {SOL_FREE, SOL_RUN, SOL_DONE} sol_t;

  state_t                     state_q, state_d;
  sol_t                       sol_q [2];
  sol_t                       sol_d [2];
  logic                       tgt_q, tgt_d;     // solver being loaded
  logic                       alt_q, alt_d;     // pick when both solvers are free
  logic                       rr_q, rr_d;       // result priority when both are done
  logic                       hold_q, hold_d;   // a presented result is waiting
  logic                       hsel_q, hsel_d;   // which solver that result is from
  logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d;

  // Job payload and per-solver result storage (no reset needed: only
  // observed once the matching control state says they are valid).
  logic [ID_BITS-1:0]         id_q;
  logic [LIMB_INDEX_BITS-1:0] nl_q;
  logic [15:0]                il_q;
  logic [ID_BITS-1:0]         jid_q [2];
  logic [15:0]                rit_q [2];

  logic free0, free1, both_free, any_free;
  logic done0, done1, any_done;
  logic sel, res_fire, job_fire, start_fire;
  logic [1:0] tgt_oh;

  assign free0     = (sol_q[0] == SOL_FREE);
  assign free1     = (sol_q[1] == SOL_FREE);
  assign both_free = free0 & free1;
  assign any_free  = free0 | free1;
  assign done0     = (sol_q[0] == SOL_DONE);
  assign done1     = (sol_q[1] == SOL_DONE);
  assign any_done  = done0 | done1;
  assign tgt_oh    = tgt_q ? 2'b10 : 2'b01;

  // A result already on the port keeps its slot until it is taken, so the
  // selection is frozen while hold_q is set.
  assign sel        = hold_q ? hsel_q : ((done0 & done1) ? rr_q : ~done0);
  assign res_valid  = any_done;
  assign res_fire   = res_valid & res_ready;
  assign res_id         = res_valid ? jid_q[sel] : '0;
  assign res_iterations = res_valid ? rit_q[sel] : '0;
  assign job_fire   = (state_q == ST_IDLE) & any_free & job_valid;
  assign start_fire = (state_q == ST_START);

  // Dispatch FSM, solver status and result arbitration: next state and outputs.
  always_comb begin
    state_d           = state_q;
    tgt_d             = tgt_q;
    alt_d             = alt_q;
    rr_d              = rr_q;
    hold_d            = hold_q;
    hsel_d            = hsel_q;
    cnt_d             = cnt_q;
    sol_d[0]          = sol_q[0];
    sol_d[1]          = sol_q[1];
    job_ready         = 1'b0;
    limb_ready        = 1'b0;
    s_wr_real_en      = 2'b00;
    s_wr_imag_en      = 2'b00;
    s_wr_index        = '0;
    s_real_data       = '0;
    s_imag_data       = '0;
    s_wr_num_limbs_en = 2'b00;
    s_wr_iter_lim_en  = 2'b00;
    s_num_limbs_data  = '0;
    s_iter_lim_data   = '0;
    s_start           = 2'b00;

    case (state_q)
      ST_IDLE: begin
        job_ready = any_free;
        if (job_fire) begin
          tgt_d   = both_free ? alt_q : ~free0;
          alt_d   = both_free ? ~alt_q : alt_q;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        limb_ready = 1'b1;
        if (limb_valid) begin
          s_wr_real_en = tgt_oh;
          s_wr_imag_en = tgt_oh;
          s_wr_index   = cnt_q;
          s_real_data  = limb_re;
          s_imag_data  = limb_im;
          if (cnt_q == nl_q) state_d = ST_CFG;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_CFG: begin
        s_wr_num_limbs_en = tgt_oh;
        s_wr_iter_lim_en  = tgt_oh;
        s_num_limbs_data  = nl_q;
        s_iter_lim_data   = il_q;
        state_d           = ST_START;
      end
      ST_START: begin
        s_start        = tgt_oh;
        sol_d[tgt_q]   = SOL_RUN;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int k = 0; k < 2; k++) begin
      if (sol_q[k] == SOL_RUN && s_out_ready[k]) sol_d[k] = SOL_DONE;
      if (res_fire && sel == k[0])               sol_d[k] = SOL_FREE;
    end

    if (res_fire) begin
      rr_d   = ~rr_q;
      hold_d = 1'b0;
    end else if (res_valid) begin
      hold_d = 1'b1;
      hsel_d = sel;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sol_q[0] <= SOL_FREE;
      sol_q[1] <= SOL_FREE;
      tgt_q    <= 1'b0;
      alt_q    <= 1'b0;
      rr_q     <= 1'b0;
      hold_q   <= 1'b0;
      hsel_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sol_q[0] <= sol_d[0];
      sol_q[1] <= sol_d[1];
      tgt_q    <= tgt_d;
      alt_q    <= alt_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      hsel_q   <= hsel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload capture: header on accept, job tag at start, iteration count at completion.
  always_ff @(posedge clock) begin
    if (job_fire) begin
      id_q <= job_id;
      nl_q <= job_num_limbs;
      il_q <= job_iter_lim;
    end
    if (start_fire) jid_q[tgt_q] <= id_q;
    for (int k = 0; k < 2; k++) begin
      if (sol_q[k] == SOL_RUN && s_out_ready[k]) rit_q[k] <= s_iterations[k*16 +: 16];
    end
  end

endmodule

// File: tb/tb_solver_scheduler.sv
// Randomized and directed bench for solver_scheduler with a job-level
// reference model and simple behavioural solver stand-ins.
module tb_solver_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        job_valid, job_ready;
  logic [7:0]  job_id;
  logic [5:0]  job_num_limbs;
  logic [15:0] job_iter_lim;
  logic        limb_valid, limb_ready;
  logic [7:0]  limb_re, limb_im;
  logic [1:0]  s_wr_real_en, s_wr_imag_en;
  logic [5:0]  s_wr_index;
  logic [7:0]  s_real_data, s_imag_data;
  logic [1:0]  s_wr_num_limbs_en, s_wr_iter_lim_en;
  logic [5:0]  s_num_limbs_data;
  logic [15:0] s_iter_lim_data;
  logic [1:0]  s_start;
  logic [1:0]  s_out_ready;
  logic [31:0] s_iterations;
  logic        res_valid, res_ready;
  logic [7:0]  res_id;
  logic [15:0] res_iterations;

  always #5 clock = ~clock;

  solver_scheduler #(.LIMB_INDEX_BITS(6), .LIMB_SIZE_BITS(8), .ID_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_num_limbs(job_num_limbs), .job_iter_lim(job_iter_lim),
    .limb_valid(limb_valid), .limb_ready(limb_ready),
    .limb_re(limb_re), .limb_im(limb_im),
    .s_wr_real_en(s_wr_real_en), .s_wr_imag_en(s_wr_imag_en),
    .s_wr_index(s_wr_index), .s_real_data(s_real_data), .s_imag_data(s_imag_data),
    .s_wr_num_limbs_en(s_wr_num_limbs_en), .s_wr_iter_lim_en(s_wr_iter_lim_en),
    .s_num_limbs_data(s_num_limbs_data), .s_iter_lim_data(s_iter_lim_data),
    .s_start(s_start), .s_out_ready(s_out_ready), .s_iterations(s_iterations),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_iterations(res_iterations)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: solver status 0=free 1=running 2=done; job phase
  // 0=waiting for header 1=streaming limbs 2=config 3=start.
  int          st [2];
  logic [7:0]  jid [2];
  logic [15:0] rit [2];
  int          phase, tgt, alt, idx, rr, held, cur_nl, n_res;
  logic [7:0]  cur_id;
  logic [15:0] cur_il;
  bit          acc_last;

  // Solver stand-ins.
  bit          pend [2];
  int          lat [2];
  bit          srdy [2];
  logic [15:0] sit [2];
  bit          sol_hold = 0;
  int          force_iter = -1;

  // Observations of the DUT.
  int          cyc = 0;
  int          n_wr_dut, n_start_dut, n_rv_dut, n_res_dut;
  logic [7:0]  last_res_id;
  logic [15:0] last_res_it;
  logic [7:0]  q_ids [$];
  int          q_cyc [$];

  function automatic void model_init();
    for (int k = 0; k < 2; k++) st[k] = 0;
    phase = 0; tgt = 0; alt = 0; idx = 0; rr = 0; held = -1;
  endfunction

  function automatic int sel_of();
    if (held >= 0) return held;
    if (st[0] == 2 && st[1] == 2) return rr;
    if (st[0] == 2) return 0;
    if (st[1] == 2) return 1;
    return -1;
  endfunction

  task automatic apply_sol();
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        if (lat[k] > 0) lat[k]--;
        if (lat[k] == 0 && !sol_hold) begin
          srdy[k] = 1; pend[k] = 0;
        end
      end
    end
    s_out_ready  = {srdy[1], srdy[0]};
    s_iterations = {sit[1], sit[0]};
  endtask

  task automatic check_outputs();
    int wr, cfg, s;
    if (reset) return;
    check("job_ready", job_ready, (phase == 0 && (st[0] == 0 || st[1] == 0)) ? 1 : 0);
    check("limb_ready", limb_ready, (phase == 1) ? 1 : 0);
    wr = (phase == 1 && limb_valid) ? (1 << tgt) : 0;
    check("wr_real_en", s_wr_real_en, wr);
    check("wr_imag_en", s_wr_imag_en, wr);
    if (wr != 0) begin
      check("wr_index", s_wr_index, idx);
      check("real_data", s_real_data, limb_re);
      check("imag_data", s_imag_data, limb_im);
    end
    cfg = (phase == 2) ? (1 << tgt) : 0;
    check("num_limbs_en", s_wr_num_limbs_en, cfg);
    check("iter_lim_en", s_wr_iter_lim_en, cfg);
    if (cfg != 0) begin
      check("num_limbs_data", s_num_limbs_data, cur_nl);
      check("iter_lim_data", s_iter_lim_data, cur_il);
    end
    check("start", s_start, (phase == 3) ? (1 << tgt) : 0);
    s = sel_of();
    check("res_valid", res_valid, (s >= 0) ? 1 : 0);
    if (s >= 0) begin
      check("res_id", res_id, jid[s]);
      check("res_iterations", res_iterations, rit[s]);
    end
    if (s_wr_real_en != 0) n_wr_dut++;
    if (s_start != 0) n_start_dut++;
    if (res_valid) n_rv_dut++;
    if (res_valid && res_ready) begin
      n_res_dut++;
      last_res_id = res_id;
      last_res_it = res_iterations;
      q_ids.push_back(res_id);
      q_cyc.push_back(cyc);
    end
  endtask

  task automatic model_update();
    int old_st [2];
    int s;
    acc_last = 0;
    if (reset) begin
      model_init();
      return;
    end
    old_st[0] = st[0]; old_st[1] = st[1];
    s = sel_of();
    if (s >= 0) begin
      if (res_ready) begin
        st[s] = 0; rr ^= 1; held = -1; n_res++;
      end else held = s;
    end
    for (int k = 0; k < 2; k++) begin
      if (old_st[k] == 1 && srdy[k]) begin
        st[k] = 2; rit[k] = sit[k];
      end
    end
    case (phase)
      0: if (job_valid && (old_st[0] == 0 || old_st[1] == 0)) begin
           if (old_st[0] == 0 && old_st[1] == 0) begin tgt = alt; alt ^= 1; end
           else tgt = (old_st[0] == 0) ? 0 : 1;
           cur_id = job_id; cur_nl = int'(job_num_limbs); cur_il = job_iter_lim;
           idx = 0; phase = 1; acc_last = 1;
         end
      1: if (limb_valid) begin
           if (idx == cur_nl) phase = 2;
           else idx++;
         end
      2: phase = 3;
      default: begin
        st[tgt] = 1; jid[tgt] = cur_id; phase = 0;
        pend[tgt] = 1; srdy[tgt] = 0; lat[tgt] = $urandom_range(1, 5);
        sit[tgt] = (force_iter >= 0) ? 16'(force_iter) : 16'($urandom);
      end
    endcase
  endtask

  task automatic step();
    apply_sol();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; job_valid = 0; limb_valid = 0;
    for (int k = 0; k < 2; k++) begin srdy[k] = 0; pend[k] = 0; end
    step(); step();
    reset = 0;
  endtask

  task automatic wait_accept(input string tag);
    int guard = 0;
    do begin step(); guard++; end while (!acc_last && guard < 200);
    check(tag, acc_last, 1);
    job_valid = 0;
  endtask

  task automatic send_job(input logic [7:0] id, input int nl, input logic [15:0] il);
    int guard = 0;
    job_valid = 1; job_id = id; job_num_limbs = 6'(nl); job_iter_lim = il;
    wait_accept("hdr_accept");
    while (phase != 0 && guard < 200) begin
      limb_valid = 1; limb_re = 8'($urandom); limb_im = 8'($urandom);
      step(); guard++;
    end
    limb_valid = 0;
    check("job_done", (phase == 0) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] re19 [3];
    logic [7:0] im19 [3];
    bit         pat23 [5];
    int         guard;
    re19 = '{8'h00, 8'h40, 8'h00};
    im19 = '{8'h00, 8'hC0, 8'h00};
    pat23 = '{1, 0, 0, 1, 1};
    for (int k = 0; k < 2; k++) begin srdy[k] = 0; pend[k] = 0; lat[k] = 0; sit[k] = 0; end
    job_valid = 0; job_id = 0; job_num_limbs = 0; job_iter_lim = 0;
    limb_valid = 0; limb_re = 0; limb_im = 0; res_ready = 0;
    s_out_ready = 0; s_iterations = 0;
    n_wr_dut = 0; n_start_dut = 0; n_rv_dut = 0; n_res_dut = 0; n_res = 0;
    model_init();
    reset = 1;
    do_reset();
    check("reset_job_ready", job_ready, 1);
    check("reset_res_valid", res_valid, 0);

    // Single job, solver returns 7.
    res_ready = 1; force_iter = 7;
    job_valid = 1; job_id = 8'h11; job_num_limbs = 6'd2; job_iter_lim = 16'd10;
    wait_accept("req019_accept");
    for (int i = 0; i < 3; i++) begin
      limb_valid = 1; limb_re = re19[i]; limb_im = im19[i];
      step();
    end
    limb_valid = 0;
    guard = 0;
    while (n_res_dut == 0 && guard < 50) begin step(); guard++; end
    check("req019_res_seen", n_res_dut, 1);
    check("req019_res_id", last_res_id, 8'h11);
    check("req019_res_iter", last_res_it, 16'd7);
    force_iter = -1;

    // Two jobs fill both solvers; third header waits; simultaneous completion.
    do_reset();
    res_ready = 0; sol_hold = 1;
    send_job(8'hA1, 1, 16'd100);
    send_job(8'hB2, 0, 16'd200);
    job_valid = 1; job_id = 8'hC3; job_num_limbs = 6'd1; job_iter_lim = 16'd5;
    repeat (4) step();
    check("req020_third_held", job_ready, 0);
    sol_hold = 0;
    step();
    q_ids.delete(); q_cyc.delete();
    repeat (5) step();
    check("req022_valid", res_valid, 1);
    check("req022_id", res_id, 8'hA1);
    check("req022_no_dispatch", job_ready, 0);
    res_ready = 1;
    send_job(8'hC3, 1, 16'd5);
    check("req021_count", (q_ids.size() >= 2) ? 1 : 0, 1);
    if (q_ids.size() >= 2) begin
      check("req021_first", q_ids[0], 8'hA1);
      check("req021_second", q_ids[1], 8'hB2);
      check("req021_consecutive", q_cyc[1] - q_cyc[0], 1);
    end

    // Limb stream with idle gaps.
    job_valid = 1; job_id = 8'h23; job_num_limbs = 6'd2; job_iter_lim = 16'd3;
    wait_accept("req023_accept");
    n_wr_dut = 0;
    for (int i = 0; i < 5; i++) begin
      limb_valid = pat23[i]; limb_re = 8'($urandom); limb_im = 8'($urandom);
      step();
    end
    limb_valid = 0;
    repeat (3) step();
    check("req023_writes", n_wr_dut, 3);

    // Reset in the middle of a load.
    guard = 0;
    while (!job_ready && guard < 100) begin step(); guard++; end
    job_valid = 1; job_id = 8'h55; job_num_limbs = 6'd3; job_iter_lim = 16'd9;
    wait_accept("req024_accept");
    limb_valid = 1; step(); limb_valid = 0;
    do_reset();
    check("req024_job_ready", job_ready, 1);
    n_start_dut = 0; n_rv_dut = 0;
    repeat (10) step();
    check("req024_no_start", n_start_dut, 0);
    check("req024_no_result", n_rv_dut, 0);

    // Randomized traffic.
    n_res = 0; n_res_dut = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!job_valid && $urandom_range(0, 2) == 0) begin
        job_valid = 1; job_id = 8'($urandom);
        job_num_limbs = 6'($urandom_range(0, 4)); job_iter_lim = 16'($urandom);
      end
      limb_valid = ($urandom_range(0, 3) != 0);
      limb_re = 8'($urandom); limb_im = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc_last) job_valid = 0;
    end
    check("random_result_count", n_res_dut, n_res);
    check("random_some_results", (n_res_dut > 10) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
